aes_io_loader: RTL and testbench
================================

# aes_io_loader

Initiator side of the AES decrypt handshake. Collects a 128-bit key and 128-bit ciphertext as 32-bit word writes from the host bus, restarts the AES controller, holds `io_ready` until the controller answers with `aes_ready`, then captures the 128-bit plaintext and serves it back to the host as four readable words. It sits between the host-facing register interface and the AES controller.

## Interface
- `TIMEOUT_CYCLES`, default 70000: watchdog limit in cycles, counted from `io_ready` rise. Used only with the timeout feature.
- `RST_CYCLES`, default 2: length of the `core_rst` pulse. Must be ≥1.
- `clk` in 1: single clock, all logic on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `wr_en` in 1: host word write strobe.
- `wr_addr` in 3: write address. 0–3 are key words, 4–7 are message words. Word 0/4 maps to bits [127:96], word 3/7 to bits [31:0].
- `wr_data` in 32: write data.
- `rd_addr` in 2: result word select. 0 selects [127:96].
- `rd_data` out 32: registered result word.
- `start` in 1: single-cycle run request.
- `busy` out 1: high from start acceptance until the DONE state is entered.
- `done` out 1: level, high in DONE.
- `timeout` out 1: sticky per run; high in DONE if the watchdog expired.
- `key` out 128: assembled key.
- `msg_en` out 128: assembled ciphertext.
- `msg_de` in 128: plaintext from the AES controller.
- `io_ready` out 1: request to the AES controller.
- `aes_ready` in 1: completion from the AES controller.
- `core_rst` out 1: active-high restart for the controller; the integrator inverts it into the controller's active-low reset.

## Operation
- Register file: 8×32 words plus an 8-bit valid mask. `wr_en` sets the mask bit for the addressed word. The mask persists until `reset`, so repeated runs reuse the loaded data.
- Writes are accepted only in IDLE and DONE. In all other states they are dropped, with no data or mask change.
- States and transitions:
  - IDLE: on `start` with the mask equal to 8'hFF, go to RESTART. A `start` with an incomplete mask is ignored.
  - RESTART: `core_rst`=1 for `RST_CYCLES` cycles, then go to ARM.
  - ARM: `io_ready`=1, timer cleared, go to WAIT_AES.
  - WAIT_AES: `io_ready`=1. When `aes_ready`=1 is sampled, go to CAPTURE.
  - CAPTURE: `io_ready`=0, latch `msg_de` into the result register, go to DONE.
  - DONE: `done`=1. On `start` (mask full), go to RESTART, clearing `done` and `timeout`.
- `start` and `wr_en` in the same cycle: `start` is evaluated against the pre-write mask; the write still completes.
- `aes_ready` high during RESTART or ARM is ignored. Only WAIT_AES samples it.
- `start` while `busy` is ignored.

## Timing
- Reset values:
  - state IDLE
  - outputs `io_ready`, `core_rst`, `busy`, `done`, `timeout` = 0
  - `rd_data` = 0
  - `key`, `msg_en`, result register and mask = 0
- `start` accepted at edge N: `busy` and `core_rst` are high from N+1, `core_rst` for `RST_CYCLES` cycles. `io_ready` rises at N+1+`RST_CYCLES`.
- `aes_ready` first sampled high at edge M: `io_ready` falls and the result is valid at M+1, `done` rises at M+2, `busy` falls at M+2.
- `rd_data` has 1-cycle latency from `rd_addr`. It always reflects the result register, which is only updated in CAPTURE.
- `key` and `msg_en` change on the edge after the write.
- Reset mid-run: all outputs return to their reset values immediately and the data is lost. The host must reload all 8 words.

## Configuration
- `AES_IO_TIMEOUT_EN` defined:
  - A counter of width $clog2(`TIMEOUT_CYCLES`+1) runs in WAIT_AES.
  - When it reaches `TIMEOUT_CYCLES` with no `aes_ready`, go to DONE with `timeout`=1, `io_ready`=0, and the result register cleared to 0.
- Undefined: WAIT_AES waits indefinitely, `timeout` is tied 0, and no counter is instantiated.

## Structure
- Package `aes_io_pkg` holds:
  - the state enum (IDLE, RESTART, ARM, WAIT_AES, CAPTURE, DONE)
  - word address constants `KEY_W0`=0 and `MSG_W0`=4
  - default `TIMEOUT_CYCLES`
- Sub-module `aes_io_regfile` holds the 8×32 storage, the valid mask, write gating, and `key`/`msg_en` assembly. The FSM, timer and result/readback logic live in the top module.

## Test plan
- Write key words 00010203, 04050607, 08090A0B, 0C0D0E0F and message words 69C4E0D8, 6A7B0430, D8CDB780, 70B4C55A, then `start`; model `aes_ready` 10 cycles after `io_ready` with `msg_de` = 00112233_44556677_8899AABB_CCDDEEFF. Required: `done`=1, and `rd_addr`=2 returns 8899AABB.
- Write only 7 words, then `start`. Required: `busy` stays 0 and `core_rst`/`io_ready` never assert.
- `start` with the default `RST_CYCLES`=2. Required: `core_rst` is high for exactly 2 cycles, then `io_ready` rises on the next cycle.
- With `AES_IO_TIMEOUT_EN` and `TIMEOUT_CYCLES`=100, hold `aes_ready`=0. Required: `done`=1 and `timeout`=1 after 100 WAIT_AES cycles, and `rd_data`=0 for every `rd_addr`.
- Write to `wr_addr`=5 with value DEADBEEF during WAIT_AES. Required: `msg_en`[95:64] is unchanged.
- Assert `reset` during WAIT_AES. Required: `io_ready`=0 and `busy`=0 immediately, and a following `start` is ignored until all 8 words are rewritten.

Source files
------------

// File: rtl/aes_io_pkg.sv
// aes_io_pkg: state encoding, word address constants and defaults for aes_io_loader.
package aes_io_pkg;
    typedef enum logic [2:0] {IDLE, RESTART, ARM, WAIT_AES, CAPTURE, DONE} state_t;
    localparam int KEY_W0 = 0;
    localparam int MSG_W0 = 4;
    localparam int TIMEOUT_CYCLES_DEF = 70000;
endpackage

// File: rtl/aes_io_regfile.sv
// aes_io_regfile: 8x32 key/message word store with valid mask and 128-bit key/ciphertext assembly.
module aes_io_regfile
    import aes_io_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         wr_en,
    input  logic         wr_allow,
    input  logic [2:0]   wr_addr,
    input  logic [31:0]  wr_data,
    output logic [7:0]   mask,
    output logic [127:0] key,
    output logic [127:0] msg_en
);
    logic [31:0] words [8];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            words <= '{default: '0};
            mask  <= '0;
        end else if (wr_en && wr_allow) begin
            words[wr_addr] <= wr_data;
            mask[wr_addr]  <= 1'b1;
        end
    end

    // Lowest word address lands in the most significant bits.
    assign key    = {words[KEY_W0], words[KEY_W0+1], words[KEY_W0+2], words[KEY_W0+3]};
    assign msg_en = {words[MSG_W0], words[MSG_W0+1], words[MSG_W0+2], words[MSG_W0+3]};
endmodule

// File: rtl/aes_io_loader.sv
// aes_io_loader: host-side initiator of the AES decrypt handshake (load, restart, wait, capture, read back).
// Optional watchdog enabled by defining AES_IO_TIMEOUT_EN.
module aes_io_loader #(
    parameter int TIMEOUT_CYCLES = aes_io_pkg::TIMEOUT_CYCLES_DEF,
    parameter int RST_CYCLES     = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr_en,
    input  logic [2:0]   wr_addr,
    input  logic [31:0]  wr_data,
    input  logic [1:0]   rd_addr,
    output logic [31:0]  rd_data,
    input  logic         start,
    output logic         busy,
    output logic         done,
    output logic         timeout,
    output logic [127:0] key,
    output logic [127:0] msg_en,
    input  logic [127:0] msg_de,
    output logic         io_ready,
    input  logic         aes_ready,
    output logic         core_rst
);
    import aes_io_pkg::*;

    localparam int RW = $clog2(RST_CYCLES) + 1;
    localparam logic [RW-1:0] RST_LAST = RW'(RST_CYCLES - 1);

    if (RST_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("aes_io_loader: RST_CYCLES and TIMEOUT_CYCLES must be >= 1");
    end

    state_t         state, state_nx;
    logic [7:0]     mask;
    logic [RW-1:0]  rst_cnt;
    logic [127:0]   result;
    logic           writable, go, expired;

    assign writable = state == IDLE || state == DONE;
    assign go       = writable && start && mask == 8'hFF;

    aes_io_regfile u_regfile (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_allow (writable),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .mask     (mask),
        .key      (key),
        .msg_en   (msg_en)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: if (go) state_nx = RESTART;
            RESTART:    if (rst_cnt == RST_LAST) state_nx = ARM;
            ARM:        state_nx = WAIT_AES;
            WAIT_AES:   state_nx = aes_ready ? CAPTURE : expired ? DONE : WAIT_AES;
            CAPTURE:    state_nx = DONE;
            default:    state_nx = IDLE;
        endcase
    end

    always_comb begin
        core_rst = state == RESTART;
        io_ready = state == ARM || state == WAIT_AES;
        busy     = state inside {RESTART, ARM, WAIT_AES, CAPTURE};
        done     = state == DONE;
    end

    // Plaintext is latched on the edge that samples aes_ready so it is valid as CAPTURE begins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rst_cnt <= '0;
            result  <= '0;
            rd_data <= '0;
        end else begin
            rst_cnt <= state == RESTART ? rst_cnt + 1'b1 : '0;
            if (state == WAIT_AES && aes_ready) result <= msg_de;
            else if (state == WAIT_AES && expired) result <= '0;
            rd_data <= result[{~rd_addr, 5'd0} +: 32];
        end
    end

`ifdef AES_IO_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] timer;
    logic          timeout_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer     <= '0;
            timeout_q <= 1'b0;
        end else begin
            timer <= state == WAIT_AES ? timer + 1'b1 : '0;
            if (go) timeout_q <= 1'b0;
            else if (state == WAIT_AES && !aes_ready && expired) timeout_q <= 1'b1;
        end
    end

    assign expired = timer == TO_LAST;
    assign timeout = timeout_q;
`else
    assign expired = 1'b0;
    assign timeout = 1'b0;
`endif
endmodule

// File: tb/tb_aes_io_loader.sv
// tb_aes_io_loader: scoreboard bench for aes_io_loader; plaintexts are queued when the AES reply is driven
// and compared word by word on readback.
module tb_aes_io_loader;
    logic         clk = 0;
    logic         reset = 1;
    logic         wr_en = 0;
    logic [2:0]   wr_addr = 0;
    logic [31:0]  wr_data = 0;
    logic [1:0]   rd_addr = 0;
    logic [31:0]  rd_data;
    logic         start = 0;
    logic         busy, done, timeout, io_ready, core_rst;
    logic [127:0] key, msg_en;
    logic [127:0] msg_de = 0;
    logic         aes_ready = 0;

    int errors = 0;
    int checks = 0;
    logic [127:0] sb [$];
    logic [31:0]  words [8] = '{32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F,
                                32'h69C4E0D8, 32'h6A7B0430, 32'hD8CDB780, 32'h70B4C55A};
    localparam logic [127:0] KEY_EXP = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [127:0] MSG_EXP = 128'h69C4E0D86A7B0430D8CDB78070B4C55A;
    localparam logic [127:0] PT1 = 128'h00112233445566778899AABBCCDDEEFF;
    localparam logic [127:0] PT2 = 128'hA5A5F00D_12345678_CAFEBABE_0BADF00D;

    always #5 clk = ~clk;

    aes_io_loader #(
`ifdef AES_IO_TIMEOUT_EN
        .TIMEOUT_CYCLES(100),
`endif
        .RST_CYCLES(2)
    ) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data), .start(start), .busy(busy), .done(done),
        .timeout(timeout), .key(key), .msg_en(msg_en), .msg_de(msg_de),
        .io_ready(io_ready), .aes_ready(aes_ready), .core_rst(core_rst)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        wr_en = 1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 0;
    endtask

    task automatic load(input int n);
        for (int i = 0; i < n; i++) wr(3'(i), words[i]);
    endtask

    task automatic probe_ignored(input string tag);
        logic seen;
        seen = 0;
        start = 1;
        @(negedge clk);
        start = 0;
        repeat (8) begin
            seen |= busy | core_rst | io_ready;
            @(negedge clk);
        end
        check(tag, seen, 0);
    endtask

    task automatic readback(input string tag);
        logic [127:0] exp;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 1, 0);
            return;
        end
        exp = sb.pop_front();
        for (int w = 0; w < 4; w++) begin
            rd_addr = 2'(w);
            @(negedge clk);
            check($sformatf("%s_w%0d", tag, w), {96'd0, rd_data}, {96'd0, exp[127-32*w -: 32]});
        end
    endtask

    // Start, count the core_rst pulse until io_ready rises; returns with io_ready sampled high.
    task automatic kick(input string tag, input bit early_ready);
        int n;
        n = 0;
        start = 1;
        @(negedge clk);
        start = 0;
        aes_ready = early_ready;
        check({tag, "_busy"}, busy, 1);
        for (int i = 0; i < 20 && !io_ready; i++) begin
            if (core_rst) n++;
            @(negedge clk);
            aes_ready = 0;
        end
        check({tag, "_rst_len"}, 128'(n), 2);
        check({tag, "_io_rise"}, io_ready, 1);
    endtask

    task automatic run(input string tag, input logic [127:0] pt, input int delay,
                       input bit early_ready, input bit poke);
        kick(tag, early_ready);
        if (poke) begin
            wr(3'd5, 32'hDEADBEEF);
            repeat (delay - 1) @(negedge clk);
            check({tag, "_locked_wr"}, {96'd0, msg_en[95:64]}, {96'd0, words[5]});
        end else begin
            repeat (delay) @(negedge clk);
        end
        check({tag, "_io_hold"}, io_ready, 1);
        aes_ready = 1; msg_de = pt;
        sb.push_back(pt);
        @(negedge clk);
        aes_ready = 0; msg_de = ~pt;
        check({tag, "_io_fall"}, io_ready, 0);
        check({tag, "_done_early"}, done, 0);
        @(negedge clk);
        check({tag, "_done"}, done, 1);
        check({tag, "_busy_off"}, busy, 0);
        check({tag, "_timeout"}, timeout, 0);
        readback(tag);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        reset = 0;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_io_ready", io_ready, 0);
        check("rst_core_rst", core_rst, 0);
        check("rst_timeout", timeout, 0);
        check("rst_rd_data", {96'd0, rd_data}, 0);
        check("rst_key", key, 0);
        check("rst_msg", msg_en, 0);

        load(7);
        probe_ignored("partial_start");
        wr(3'd7, words[7]);
        check("key_asm", key, KEY_EXP);
        check("msg_asm", msg_en, MSG_EXP);

        run("run1", PT1, 10, 0, 1);
        run("run2", PT2, 3, 1, 0);

`ifdef AES_IO_TIMEOUT_EN
        begin
            int n;
            kick("to", 0);
            n = 0;
            while (!done && n < 300) begin
                @(negedge clk);
                n++;
            end
            check("to_cycles", 128'(n), 101);
            check("to_done", done, 1);
            check("to_flag", timeout, 1);
            check("to_io", io_ready, 0);
            sb.push_back(128'd0);
            readback("to");
        end
`endif

        kick("rst_mid", 0);
        repeat (2) @(negedge clk);
        #2 reset = 1;
        #1;
        check("rst_mid_io", io_ready, 0);
        check("rst_mid_busy", busy, 0);
        @(negedge clk);
        reset = 0;
        check("rst_mid_key", key, 0);
        probe_ignored("rst_mid_start0");
        load(7);
        probe_ignored("rst_mid_start7");
        wr(3'd7, words[7]);
        run("run3", PT1, 10, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
